// File: rtl/dlx_pkg.sv
// dlx_pkg: opcode / function-code constants, field positions and shared
// enums for the DLX instruction encoder (and its decoder counterpart).
// Optional build macro: DLX_ENC_RANGE_CHECK_EN (enables immediate-fit helpers use).
package dlx_pkg;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_FTYPE = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDUI = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_SUBUI = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SRAI  = 6'h17;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SGTI  = 6'h1B;
    localparam logic [5:0] OP_SLEI  = 6'h1C;
    localparam logic [5:0] OP_SGEI  = 6'h1D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'h04;
    localparam logic [5:0] FN_SRL  = 6'h06;
    localparam logic [5:0] FN_SRA  = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    // Field bit positions
    localparam int OP_LSB   = 26;
    localparam int RS1_LSB  = 21;
    localparam int RS2_LSB  = 16;
    localparam int RD_R_LSB = 11;
    localparam int RD_I_LSB = 16;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} dlx_fmt_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FULL} enc_state_e;

    // Immediate-fit helpers for the optional range check
    function automatic logic fits_s16(input logic [25:0] imm);
        return (&imm[25:15]) || !(|imm[25:15]);
    endfunction

    function automatic logic fits_u16(input logic [25:0] imm);
        return !(|imm[25:16]);
    endfunction

    function automatic logic fits_u5(input logic [25:0] imm);
        return !(|imm[25:5]);
    endfunction

endpackage

// File: rtl/dlx_inst_encoder_if.sv
// dlx_inst_encoder_if: request bus into the encoder plus the
// instruction-memory write bus out of it.
interface dlx_inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [5:0]        in_func;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    // Requester / memory side
    modport master (
        output in_valid, in_opcode, in_func, in_rs1, in_rs2, in_rd, in_imm, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    // Encoder side
    modport slave (
        input  in_valid, in_opcode, in_func, in_rs1, in_rs2, in_rd, in_imm, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/dlx_field_pack.sv
// dlx_field_pack: combinational field packer. Picks the format from the
// opcode, assembles the 32-bit word and flags illegal requests.
// Optional build macro: DLX_ENC_RANGE_CHECK_EN (immediates that do not fit
// their field become illegal instead of being truncated).
module dlx_field_pack
    import dlx_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  func_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [25:0] imm_i,
    output dlx_fmt_e    fmt_o,
    output logic [31:0] word_o,
    output logic        legal_o
);
    logic op_legal;

    // Format select and word assembly; defaults cover the plain I-type case
    always_comb begin
        fmt_o    = FMT_I;
        word_o   = {opcode_i, rs1_i, rd_i, imm_i[15:0]};
        op_legal = 1'b1;
        case (opcode_i)
            OP_RTYPE, OP_FTYPE: begin
                fmt_o  = FMT_R;
                word_o = {opcode_i, rs1_i, rs2_i, rd_i, 5'b0, func_i};
            end
            OP_J, OP_JAL: begin
                fmt_o  = FMT_J;
                word_o = {opcode_i, imm_i};
            end
            OP_JR, OP_JALR: begin
                word_o = {opcode_i, rs1_i, 5'b0, 16'b0};
            end
            OP_BEQZ, OP_BNEZ, OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI,
            OP_ANDI, OP_ORI, OP_XORI, OP_LHI,
            OP_SLLI, OP_SRLI, OP_SRAI,
            OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: ;
            default: op_legal = 1'b0;
        endcase
    end

`ifdef DLX_ENC_RANGE_CHECK_EN
    logic rng_ok;

    // Immediate must be representable in the field the opcode uses
    always_comb begin
        rng_ok = 1'b1;
        case (opcode_i)
            OP_BEQZ, OP_BNEZ, OP_ADDI, OP_SUBI,
            OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:                       rng_ok = fits_s16(imm_i);
            OP_ADDUI, OP_SUBUI, OP_ANDI, OP_ORI,
            OP_XORI, OP_LHI:                           rng_ok = fits_u16(imm_i);
            OP_SLLI, OP_SRLI, OP_SRAI:                 rng_ok = fits_u5(imm_i);
            default:                                   rng_ok = 1'b1;
        endcase
    end

    assign legal_o = op_legal && rng_ok;
`else
    assign legal_o = op_legal;
`endif

endmodule

// File: rtl/dlx_inst_encoder.sv
// dlx_inst_encoder: accepts field requests, packs them into DLX words and
// streams them to the instruction memory at auto-incrementing addresses.
// Owns the run/drain/full FSM, address counter, output register and error
// tracking. Optional build macro: DLX_ENC_RANGE_CHECK_EN.
module dlx_inst_encoder
    import dlx_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    dlx_inst_encoder_if.slave   bus,
    output logic                err,
    output logic [7:0]          err_count,
    output logic                full
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

    enc_state_e        state_q, state_d;
    logic              out_vld_q, out_vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              in_rdy;
    logic              accept;
    logic              wr_fire;
    logic [ADDR_W-1:0] tgt_addr;

    dlx_fmt_e          pack_fmt;
    logic [31:0]       pack_word;
    logic              pack_legal;

    dlx_field_pack u_pack (
        .opcode_i (bus.in_opcode),
        .func_i   (bus.in_func),
        .rs1_i    (bus.in_rs1),
        .rs2_i    (bus.in_rs2),
        .rd_i     (bus.in_rd),
        .imm_i    (bus.in_imm),
        .fmt_o    (pack_fmt),
        .word_o   (pack_word),
        .legal_o  (pack_legal)
    );

    // Next-state, counter and output-register update
    always_comb begin
        state_d   = state_q;
        out_vld_d = out_vld_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        in_rdy  = (state_q == ST_RUN) && (!out_vld_q || bus.wr_ready);
        accept  = bus.in_valid && in_rdy;
        wr_fire = out_vld_q && bus.wr_ready;
        // An accept alongside a completing write lands one slot further on
        tgt_addr = out_vld_q ? addr_q + 1'b1 : addr_q;

        if (wr_fire) begin
            out_vld_d = 1'b0;
            if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
        end

        if (accept) begin
            if (pack_legal) begin
                out_vld_d = 1'b1;
                data_d    = pack_word;
                if (tgt_addr == ADDR_MAX) state_d = ST_DRAIN;
            end else begin
                err_d = 1'b1;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
        end

        case (state_q)
            ST_IDLE, ST_FULL: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = ADDR_BASE;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            ST_DRAIN: if (wr_fire) state_d = ST_FULL;
            default: ;
        endcase
    end

    // State and datapath registers; reset discards any pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_vld_q <= 1'b0;
            addr_q    <= ADDR_BASE;
            data_q    <= 32'd0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= out_vld_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // A legal J-type word always carries the raw 26-bit offset
    always_comb begin
        if (pack_legal && pack_fmt == FMT_J) assert (pack_word[25:0] == bus.in_imm);
    end

    assign bus.in_ready = in_rdy;
    assign bus.wr_valid = out_vld_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign err          = err_q;
    assign err_count    = cnt_q;
    assign full         = (state_q == ST_FULL);

endmodule
